// File: rtl/seq_mul_4b.sv
// rtl/seq_mul_4b.sv - sequential shift-and-add unsigned multiplier with start/busy/done handshake
module seq_mul_4b #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic [2*WIDTH-1:0] acc_next;
  logic               accept;

  // Partial product for this iteration: multiplicand gated by the current multiplier LSB
  always_comb begin
    addend = acc_lo[0] ? mcand : '0;
  end

  // Ripple-carry add of acc_hi and addend, one full-adder cell per bit, carry-in 0
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = acc_hi[i] ^ addend[i] ^ carry[i];
      carry[i + 1] = (acc_hi[i] & addend[i]) | (addend[i] & carry[i]) | (acc_hi[i] & carry[i]);
    end
  end

  // Shifted accumulator: the add's carry-out becomes the new MSB so no bit is lost
  always_comb begin
    acc_next = {carry[WIDTH], sum, acc_lo[WIDTH-1:1]};
  end

  // A new request is taken whenever no operation is running (IDLE or the DONE cycle)
  always_comb begin
    accept = start && (state != S_RUN);
    busy   = (state == S_RUN);
    done   = (state == S_DONE);
  end

  // Control FSM plus accumulator, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_RUN: begin
          {acc_hi, acc_lo} <= acc_next;
          cnt              <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            product <= acc_next;
            state   <= S_DONE;
          end
        end
        default: begin
          if (accept) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
